// File: rtl/ddr_local_master_pkg.sv
// Shared types and defaults for the DDR local_* initiator.
// Holds the FSM state encoding and the timer width helper.
package ddr_local_master_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT_WR,
    ST_WAIT_RD,
    ST_TURN,
    ST_RSP
  } state_e;

  localparam int unsigned DEF_AW      = 26;
  localparam int unsigned DEF_DW      = 128;
  localparam int unsigned DEF_TIMEOUT = 1024;

  function automatic int unsigned tmr_width(
    input int unsigned cycles
  );
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/ddr_local_master_if.sv
// Client request/response plus DDR local_* signals.
// master = the initiator block, slave = client and DDR side.
interface ddr_local_master_if #(
  parameter int unsigned AW = 26,
  parameter int unsigned DW = 128
);

  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          wr_ack;
  logic          err_sticky;
  logic          local_init_done;
  logic [AW-1:0] local_address;
  logic          local_burstbegin;
  logic          local_ready;
  logic          local_read_req;
  logic [DW-1:0] local_rdata;
  logic          local_rdata_valid;
  logic          local_write_req;
  logic [DW-1:0] local_wdata;

  modport master (
    input  req_valid, req_write,
    input  req_addr, req_wdata,
    input  rsp_ready, local_init_done,
    input  local_ready, local_rdata,
    input  local_rdata_valid,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err,
    output wr_ack, err_sticky,
    output local_address,
    output local_burstbegin,
    output local_read_req,
    output local_write_req,
    output local_wdata
  );

  modport slave (
    output req_valid, req_write,
    output req_addr, req_wdata,
    output rsp_ready, local_init_done,
    output local_ready, local_rdata,
    output local_rdata_valid,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err,
    input  wr_ack, err_sticky,
    input  local_address,
    input  local_burstbegin,
    input  local_read_req,
    input  local_write_req,
    input  local_wdata
  );

endinterface

// File: rtl/ddr_wait_timer.sv
// Ack wait timer: cleared on request launch, counts WAIT cycles.
// expired_o is high in the LIMIT-th WAIT cycle.
module ddr_wait_timer
  import ddr_local_master_pkg::*;
#(
  parameter int unsigned LIMIT = DEF_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = tmr_width(LIMIT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired_o = (cnt_q == CW'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ddr_local_master.sv
// Single-beat initiator for the DDR local_* interface
// with ack timeout and sticky error reporting.
module ddr_local_master
  import ddr_local_master_pkg::*;
#(
  parameter int unsigned DDR_ADDR_WIDTH = DEF_AW,
  parameter int unsigned DDR_DATA_WIDTH = DEF_DW,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input logic phy_clk,
  input logic rst,
  ddr_local_master_if.master bus
);

  localparam int unsigned AW = DDR_ADDR_WIDTH;
  localparam int unsigned DW = DDR_DATA_WIDTH;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          wreq_q, wreq_d;
  logic          rreq_q, rreq_d;
  logic          bb_q, bb_d;
  logic          rsp_v_q, rsp_v_d;
  logic          rsp_err_q, rsp_err_d;
  logic          wr_ack_q, wr_ack_d;
  logic          err_q, err_d;

  logic tmr_clr;
  logic tmr_en;
  logic tmr_exp;
  logic wr_hit;
  logic rd_hit;

  ddr_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i     (phy_clk),
    .rst_i     (rst),
    .clear_i   (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_exp)
  );

  // burstbegin marks the first WAIT cycle, where acks are never taken
  assign wr_hit = !bb_q && bus.local_ready;
  assign rd_hit = !bb_q && bus.local_rdata_valid;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    wreq_d    = wreq_q;
    rreq_d    = rreq_q;
    bb_d      = 1'b0;
    rsp_v_d   = rsp_v_q;
    rsp_err_d = rsp_err_q;
    wr_ack_d  = 1'b0;
    err_d     = err_q;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        if (bus.local_init_done) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          bb_d    = 1'b1;
          tmr_clr = 1'b1;
          wreq_d  = bus.req_write;
          rreq_d  = !bus.req_write;
          state_d = bus.req_write ? ST_WAIT_WR
                                  : ST_WAIT_RD;
        end else if (!bus.local_init_done) begin
          state_d = ST_INIT;
        end
      end
      ST_WAIT_WR: begin
        tmr_en = 1'b1;
        if (wr_hit || tmr_exp) begin
          wreq_d   = 1'b0;
          wr_ack_d = 1'b1;
          err_d    = err_q | !wr_hit;
          state_d  = ST_TURN;
        end
      end
      ST_WAIT_RD: begin
        tmr_en = 1'b1;
        if (rd_hit || tmr_exp) begin
          rreq_d    = 1'b0;
          rsp_v_d   = 1'b1;
          rsp_err_d = !rd_hit;
          rdata_d   = rd_hit ? bus.local_rdata : '0;
          err_d     = err_q | !rd_hit;
          state_d   = ST_RSP;
        end
      end
      ST_TURN: begin
        state_d = ST_IDLE;
      end
      ST_RSP: begin
        if (bus.rsp_ready) begin
          rsp_v_d   = 1'b0;
          rsp_err_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge phy_clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      wreq_q    <= 1'b0;
      rreq_q    <= 1'b0;
      bb_q      <= 1'b0;
      rsp_v_q   <= 1'b0;
      rsp_err_q <= 1'b0;
      wr_ack_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      wreq_q    <= wreq_d;
      rreq_q    <= rreq_d;
      bb_q      <= bb_d;
      rsp_v_q   <= rsp_v_d;
      rsp_err_q <= rsp_err_d;
      wr_ack_q  <= wr_ack_d;
      err_q     <= err_d;
    end
  end

  assign bus.req_ready        = (state_q == ST_IDLE);
  assign bus.rsp_valid        = rsp_v_q;
  assign bus.rsp_rdata        = rdata_q;
  assign bus.rsp_err          = rsp_err_q;
  assign bus.wr_ack           = wr_ack_q;
  assign bus.err_sticky       = err_q;
  assign bus.local_address    = addr_q;
  assign bus.local_burstbegin = bb_q;
  assign bus.local_read_req   = rreq_q;
  assign bus.local_write_req  = wreq_q;
  assign bus.local_wdata      = wdata_q;

endmodule

// File: tb/tb_ddr_local_master.sv
// Bench for ddr_local_master against a 1-cycle pseudo-DDR
// responder, with a memory reference model of expected reads.
module tb_ddr_local_master;

  localparam int AW = 26;
  localparam int DW = 128;
  localparam int TO = 16;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  bit ack_en;
  bit stale_ack;
  logic          rsp_rdy_q;
  logic          rsp_rv_q;
  logic [DW-1:0] rsp_data_q;
  logic [DW-1:0] mem     [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  ddr_local_master_if #(.AW(AW), .DW(DW)) bus ();

  ddr_local_master #(
    .DDR_ADDR_WIDTH (AW),
    .DDR_DATA_WIDTH (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .phy_clk (clk),
    .rst     (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pseudo-DDR: acks one cycle after it samples a req
  always @(posedge clk) begin
    if (rst) begin
      rsp_rdy_q <= 1'b0;
      rsp_rv_q  <= 1'b0;
    end else begin
      rsp_rdy_q <= ack_en && bus.local_write_req;
      rsp_rv_q  <= ack_en && bus.local_read_req;
      if (ack_en && bus.local_write_req)
        mem[bus.local_address] = bus.local_wdata;
      if (ack_en && bus.local_read_req)
        rsp_data_q <= mem.exists(bus.local_address)
                      ? mem[bus.local_address] : '0;
    end
  end

  assign bus.local_ready       = rsp_rdy_q | stale_ack;
  assign bus.local_rdata_valid = rsp_rv_q | stale_ack;
  assign bus.local_rdata       = rsp_data_q;

  function automatic logic [DW-1:0] ref_rd(
    input logic [AW-1:0] a
  );
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  function automatic logic [8:0] outs();
    return {bus.req_ready, bus.rsp_valid,
            bus.rsp_err, bus.wr_ack,
            bus.err_sticky, bus.local_burstbegin,
            bus.local_read_req, bus.local_write_req,
            |{bus.rsp_rdata, bus.local_wdata,
              bus.local_address}};
  endfunction

  // drives one transaction from an IDLE negedge and records
  // per-cycle observations; cycle n=1 is the cycle after accept
  task automatic txn(
    input  bit            wr,
    input  logic [AW-1:0] a,
    input  logic [DW-1:0] d,
    input  bit            stale1,
    input  int            hold,
    output int            ack_c,
    output int            rsp_c,
    output int            rdy_c,
    output int            wreq_n,
    output int            rreq_n,
    output int            bb_n,
    output int            bad,
    output logic [DW-1:0] rd,
    output logic          er,
    output logic          acc_rdy
  );
    bit done;
    ack_c = -1; rsp_c = -1; rdy_c = -1;
    wreq_n = 0; rreq_n = 0; bb_n = 0; bad = 0;
    rd = 'x; er = 1'bx; done = 0;
    if (wr && ack_en) ref_mem[a] = d;
    acc_rdy = bus.req_ready;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (stale1) stale_ack = 1'b1;
    for (int n = 1; n <= 40 && !done; n++) begin
      if (n > 1) @(negedge clk);
      if (n == 2) stale_ack = 1'b0;
      wreq_n += int'(bus.local_write_req);
      rreq_n += int'(bus.local_read_req);
      bb_n   += int'(bus.local_burstbegin);
      if (bus.local_write_req && bus.local_read_req)
        bad++;
      if (bus.wr_ack && ack_c < 0) ack_c = n;
      if (wr && ack_c > 0 && bus.req_ready) begin
        rdy_c = n;
        done = 1;
      end
      if (!wr && bus.rsp_valid) begin
        rsp_c = n;
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        done = 1;
      end
    end
    stale_ack = 1'b0;
    if (!wr && rsp_c > 0) begin
      bus.req_valid = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (bus.rsp_valid !== 1'b1 ||
            bus.rsp_rdata !== rd ||
            bus.req_ready !== 1'b0 ||
            bus.local_read_req !== 1'b0 ||
            bus.local_write_req !== 1'b0)
          bad++;
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [8:0] o;
    o = outs();
    checks++;
    if (o !== 9'd0) begin
      failures++;
      $display("FAIL reset_outs got=%b exp=0", o);
    end
  endtask

  task automatic test_init_gating();
    logic [DW-1:0] d;
    bit seen;
    d = {$urandom, $urandom, $urandom, $urandom};
    rst = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 26'h7;
    bus.req_wdata = d;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.req_ready, bus.local_read_req,
           bus.local_write_req} !== 3'b000) begin
        failures++;
        $display("FAIL init_gate cyc=%0d got=%b exp=000",
                 i, {bus.req_ready, bus.local_read_req,
                     bus.local_write_req});
      end
    end
    bus.local_init_done = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL init_ready got=%b exp=1",
               bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++;
    if ({bus.local_write_req, bus.local_burstbegin,
         bus.local_address} !== {2'b11, 26'h7}) begin
      failures++;
      $display("FAIL init_accept got=%b%b %h exp=11 7",
               bus.local_write_req, bus.local_burstbegin,
               bus.local_address);
    end
    ref_mem[26'h7] = d;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.req_ready;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL init_txn_done got=0 exp=1");
    end
  endtask

  task automatic test_write();
    int ac, rc, yc, wn, rn, bn, bad;
    logic [DW-1:0] rd;
    logic er, ar;
    txn(1'b1, 26'h123,
        128'h0000_0000_DEAD_BEEF_0123_4567_89AB_CDEF,
        1'b0, 0, ac, rc, yc, wn, rn, bn, bad, rd, er, ar);
    checks++;
    if (ar !== 1'b1) begin
      failures++;
      $display("FAIL wr_accept_ready got=%b exp=1", ar);
    end
    checks++;
    if (wn !== 2) begin
      failures++;
      $display("FAIL wr_req_cycles got=%0d exp=2", wn);
    end
    checks++;
    if (bn !== 1) begin
      failures++;
      $display("FAIL wr_burstbegin got=%0d exp=1", bn);
    end
    checks++;
    if (ac !== 3) begin
      failures++;
      $display("FAIL wr_ack_cycle got=%0d exp=3", ac);
    end
    checks++;
    if (yc !== 4) begin
      failures++;
      $display("FAIL wr_ready_cycle got=%0d exp=4", yc);
    end
  endtask

  task automatic test_read_hold();
    int ac, rc, yc, wn, rn, bn, bad;
    logic [DW-1:0] rd;
    logic er, ar;
    txn(1'b0, 26'h123, '0, 1'b0, 4,
        ac, rc, yc, wn, rn, bn, bad, rd, er, ar);
    checks++;
    if (rc !== 3) begin
      failures++;
      $display("FAIL rd_rsp_cycle got=%0d exp=3", rc);
    end
    checks++;
    if (rd !== ref_rd(26'h123)) begin
      failures++;
      $display("FAIL rd_data got=%h exp=%h",
               rd, ref_rd(26'h123));
    end
    checks++;
    if (er !== 1'b0 || rn !== 2) begin
      failures++;
      $display("FAIL rd_err_req got=%b/%0d exp=0/2", er, rn);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL rd_hold_stable got=%0d exp=0", bad);
    end
  endtask

  task automatic test_back_to_back();
    int ac, rc, yc, wn, rn, bn, bad;
    logic [DW-1:0] rd;
    logic er, ar;
    txn(1'b1, 26'h10, 128'd1, 1'b1, 0,
        ac, rc, yc, wn, rn, bn, bad, rd, er, ar);
    checks++;
    if (ac !== 3 || yc !== 4) begin
      failures++;
      $display("FAIL b2b_wr got=%0d/%0d exp=3/4", ac, yc);
    end
    txn(1'b0, 26'h10, '0, 1'b1, 0,
        ac, rc, yc, wn, rn, bn, bad, rd, er, ar);
    checks++;
    if (ar !== 1'b1 || rc !== 3) begin
      failures++;
      $display("FAIL b2b_rd_timing got=%b/%0d exp=1/3",
               ar, rc);
    end
    checks++;
    if (rd !== ref_rd(26'h10)) begin
      failures++;
      $display("FAIL b2b_rd_data got=%h exp=%h",
               rd, ref_rd(26'h10));
    end
  endtask

  task automatic test_timeout();
    int ac, rc, yc, wn, rn, bn, bad;
    logic [DW-1:0] rd;
    logic er, ar;
    ack_en = 1'b0;
    txn(1'b0, 26'h5, '0, 1'b0, 1,
        ac, rc, yc, wn, rn, bn, bad, rd, er, ar);
    checks++;
    if (rc !== TO + 1 || rn !== TO) begin
      failures++;
      $display("FAIL to_rd_cycles got=%0d/%0d exp=%0d/%0d",
               rc, rn, TO + 1, TO);
    end
    checks++;
    if (er !== 1'b1 || rd !== '0) begin
      failures++;
      $display("FAIL to_rd_err got=%b %h exp=1 0", er, rd);
    end
    checks++;
    if (bus.err_sticky !== 1'b1) begin
      failures++;
      $display("FAIL to_sticky got=%b exp=1",
               bus.err_sticky);
    end
    txn(1'b1, 26'h30, 128'hABCD, 1'b0, 0,
        ac, rc, yc, wn, rn, bn, bad, rd, er, ar);
    checks++;
    if (ac !== TO + 1 || yc !== TO + 2 || wn !== TO) begin
      failures++;
      $display("FAIL to_wr got=%0d/%0d/%0d exp=%0d/%0d/%0d",
               ac, yc, wn, TO + 1, TO + 2, TO);
    end
    ack_en = 1'b1;
    txn(1'b0, 26'h30, '0, 1'b0, 0,
        ac, rc, yc, wn, rn, bn, bad, rd, er, ar);
    checks++;
    if (rc !== 3 || er !== 1'b0 || rd !== ref_rd(26'h30)) begin
      failures++;
      $display("FAIL to_recover got=%0d %b %h exp=3 0 %h",
               rc, er, rd, ref_rd(26'h30));
    end
    checks++;
    if (bus.err_sticky !== 1'b1) begin
      failures++;
      $display("FAIL to_sticky_hold got=%b exp=1",
               bus.err_sticky);
    end
  endtask

  task automatic test_random();
    int ac, rc, yc, wn, rn, bn, bad;
    logic [DW-1:0] rd, d;
    logic [AW-1:0] a;
    logic er, ar;
    bit wr, st;
    int hold;
    for (int i = 0; i < 40; i++) begin
      wr   = 1'($urandom_range(0, 1));
      st   = 1'($urandom_range(0, 1));
      hold = $urandom_range(0, 3);
      a    = 26'h200 + 26'($urandom_range(0, 7));
      d    = {$urandom, $urandom, $urandom, $urandom};
      txn(wr, a, d, st, hold,
          ac, rc, yc, wn, rn, bn, bad, rd, er, ar);
      checks++;
      if (ar !== 1'b1 || bad !== 0 || bn !== 1) begin
        failures++;
        $display("FAIL rnd_proto i=%0d got=%b/%0d/%0d exp=1/0/1",
                 i, ar, bad, bn);
      end
      if (wr) begin
        checks++;
        if (ac !== 3 || yc !== 4 || wn !== 2 || rn !== 0) begin
          failures++;
          $display("FAIL rnd_wr i=%0d got=%0d/%0d/%0d/%0d exp=3/4/2/0",
                   i, ac, yc, wn, rn);
        end
      end else begin
        checks++;
        if (rc !== 3 || rn !== 2 || er !== 1'b0 ||
            rd !== ref_rd(a)) begin
          failures++;
          $display("FAIL rnd_rd i=%0d got=%0d/%0d/%b %h exp=3/2/0 %h",
                   i, rc, rn, er, rd, ref_rd(a));
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int ac, rc, yc, wn, rn, bn, bad;
    logic [DW-1:0] rd;
    logic er, ar;
    logic [8:0] o;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 26'h123;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++;
    if (bus.local_read_req !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_c1_req got=%b exp=1",
               bus.local_read_req);
    end
    rst = 1'b1;
    @(negedge clk);
    o = outs();
    checks++;
    if (o !== 9'd0) begin
      failures++;
      $display("FAIL rstmid_outs got=%b exp=0", o);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_idle got=%b%b exp=10",
               bus.req_ready, bus.rsp_valid);
    end
    txn(1'b0, 26'h123, '0, 1'b0, 0,
        ac, rc, yc, wn, rn, bn, bad, rd, er, ar);
    checks++;
    if (rc !== 3 || rd !== ref_rd(26'h123) || er !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_read got=%0d %h %b exp=3 %h 0",
               rc, rd, er, ref_rd(26'h123));
    end
    checks++;
    if (bus.err_sticky !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_sticky got=%b exp=0",
               bus.err_sticky);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    checks = 0;
    failures = 0;
    ack_en = 1'b1;
    stale_ack = 1'b0;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.local_init_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_init_gating();
    test_write();
    test_read_hold();
    test_back_to_back();
    test_timeout();
    test_random();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
